// File: rtl/iq_bram_reader.sv
// Streams a window of IQ samples out of a circular BRAM onto an AXI-Stream style port,
// never reading past the writer's current address and flagging when the writer laps the reader.
module iq_bram_reader #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       wr_count,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   length,
  output logic              bram_en,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [DATA_W-1:0] bram_dout,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  output logic              m_tlast,
  input  logic              m_tready,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, FINISH} state_t;

  localparam logic [ADDR_W:0]   MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   ONE_L   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ONE_A   = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_prev_q;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [ADDR_W:0]     issue_cnt_q, issue_cnt_d;
  logic [ADDR_W:0]     beat_cnt_q, beat_cnt_d;
  logic                inflight_q;
  logic [1:0]          count_q, count_d;
  logic [DATA_W-1:0]   buf0_q, buf0_d, buf1_q, buf1_d;
  logic                ovr_q, ovr_d;

  logic [ADDR_W:0]     len_clamped;
  logic                pop;
  logic                rd_en;
  logic [2:0]          occ;
  logic [1:0]          slot;
  logic                unused_wr;

  assign unused_wr   = ^wr_count;
  assign len_clamped = (length > MAX_LEN) ? MAX_LEN : length;
  assign pop         = (count_q != 2'd0) && m_tready;

  // Occupancy after this cycle's pop lets a read issue behind a draining beat,
  // which is what sustains one beat per cycle with only two buffer slots.
  assign occ   = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign rd_en = (state_q == READ) && (issue_cnt_q != '0) &&
                 (rd_addr_q != wr_ptr_q) && (occ < 3'd2);

  assign bram_en   = rd_en;
  assign bram_addr = rd_addr_q;
  assign m_tdata   = buf0_q;
  assign m_tvalid  = (count_q != 2'd0);
  assign m_tlast   = m_tvalid && (beat_cnt_q == ONE_L);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FINISH);
  assign overrun   = ovr_q;

  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    issue_cnt_d = issue_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    ovr_d       = ovr_q;

    if (pop) beat_cnt_d = beat_cnt_q - ONE_L;

    if (((state_q == READ) || (state_q == DRAIN)) && (wr_ptr_q != wr_prev_q) &&
        (wr_ptr_q == rd_addr_q) && (issue_cnt_q != '0))
      ovr_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          rd_addr_d   = start_addr;
          issue_cnt_d = len_clamped;
          beat_cnt_d  = len_clamped;
          ovr_d       = 1'b0;
          state_d     = (len_clamped == '0) ? FINISH : READ;
        end
      end
      READ: begin
        if (rd_en) begin
          rd_addr_d   = rd_addr_q + ONE_A;
          issue_cnt_d = issue_cnt_q - ONE_L;
          if (issue_cnt_q == ONE_L) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && (beat_cnt_q == ONE_L)) state_d = FINISH;
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q + {1'b0, inflight_q} - {1'b0, pop};
    buf0_d  = buf0_q;
    buf1_d  = buf1_q;
    slot    = count_q - {1'b0, pop};
    if (pop) buf0_d = buf1_q;
    if (inflight_q) begin
      if (slot == 2'd0) buf0_d = bram_dout;
      else              buf1_d = bram_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      wr_prev_q   <= '0;
      rd_addr_q   <= '0;
      issue_cnt_q <= '0;
      beat_cnt_q  <= '0;
      inflight_q  <= 1'b0;
      count_q     <= '0;
      buf0_q      <= '0;
      buf1_q      <= '0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_count[ADDR_W+1:2];
      wr_prev_q   <= wr_ptr_q;
      rd_addr_q   <= rd_addr_d;
      issue_cnt_q <= issue_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      inflight_q  <= rd_en;
      count_q     <= count_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
      ovr_q       <= ovr_d;
    end
  end

endmodule

// File: tb/tb_iq_bram_reader.sv
// Directed bench for iq_bram_reader; BRAM word at address a is {8'hC3, 10'h0, a}.
module tb_iq_bram_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] wr_count = 16'h0;
  logic        start = 1'b0;
  logic [13:0] start_addr = '0;
  logic [14:0] length = '0;
  logic        bram_en;
  logic [13:0] bram_addr;
  logic [31:0] bram_dout = '0;
  logic [31:0] m_tdata;
  logic        m_tvalid, m_tlast;
  logic        m_tready = 1'b1;
  logic        busy, done, overrun;

  iq_bram_reader #(.ADDR_W(14), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .wr_count(wr_count), .start(start),
    .start_addr(start_addr), .length(length), .bram_en(bram_en),
    .bram_addr(bram_addr), .bram_dout(bram_dout), .m_tdata(m_tdata),
    .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bram_en) bram_dout <= {8'hC3, 10'h000, bram_addr};

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  always @(posedge clk) cyc++;

  logic [31:0] bd[$];
  logic        bl[$];
  int          bc[$];
  int          dq[$];
  int          busy_cnt = 0;
  logic        ovr_seen = 1'b0;
  logic        stall_prev = 1'b0;
  logic [33:0] stall_word = '0;

  // Outputs are sampled mid-cycle; a handshake seen here transfers at the next rising edge.
  always @(negedge clk) begin
    if (stall_prev && !rst) check("stall_hold", {m_tvalid, m_tlast, m_tdata}, stall_word);
    stall_prev = m_tvalid && !m_tready;
    stall_word = {m_tvalid, m_tlast, m_tdata};
    if (m_tvalid && m_tready) begin
      bd.push_back(m_tdata);
      bl.push_back(m_tlast);
      bc.push_back(cyc);
    end
    if (done) dq.push_back(cyc);
    if (busy) busy_cnt++;
    if (overrun) ovr_seen = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    bd.delete(); bl.delete(); bc.delete(); dq.delete();
    busy_cnt = 0;
    ovr_seen = 1'b0;
  endtask

  task automatic pulse_start(input logic [13:0] a, input logic [14:0] l, output int t);
    start_addr = a;
    length     = l;
    start      = 1'b1;
    t          = cyc;
    tick();
    start      = 1'b0;
  endtask

  task automatic run_until_done(input int bound);
    int k;
    k = 0;
    while (dq.size() == 0 && k < bound) begin
      tick();
      k++;
    end
    tick();
    check("done_count", dq.size(), 1);
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"},    busy, 0);
    check({tag, "_done"},    done, 0);
    check({tag, "_overrun"}, overrun, 0);
    check({tag, "_tvalid"},  m_tvalid, 0);
    check({tag, "_tlast"},   m_tlast, 0);
    check({tag, "_bram_en"}, bram_en, 0);
    check({tag, "_addr"},    bram_addr, 0);
  endtask

  logic [31:0] exp4[4];
  int t0, err_d, err_l;

  initial begin
    // Reset
    repeat (3) tick();
    check_idle_zero("rst");
    rst = 1'b0;
    tick();

    // Basic readout with an ignored start while busy
    wr_count = 16'h0100;
    m_tready = 1'b1;
    tick(); tick();
    clear_mon();
    pulse_start(14'h0010, 15'd4, t0);
    start_addr = 14'h3000; length = 15'd1; start = 1'b1;
    tick();
    start = 1'b0;
    run_until_done(50);
    repeat (5) tick();
    exp4 = '{32'hC300_0010, 32'hC300_0011, 32'hC300_0012, 32'hC300_0013};
    check("b_beats", bd.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check("b_data", bd[i], exp4[i]);
      check("b_last", bl[i], (i == 3));
      check("b_cycle", bc[i], t0 + 3 + i);
    end
    check("b_done_cyc", dq[0], t0 + 7);
    check("b_done_once", dq.size(), 1);
    check("b_ovr", ovr_seen, 0);

    // Address wrap
    wr_count = 16'h0040;
    tick(); tick();
    clear_mon();
    pulse_start(14'h3FFE, 15'd4, t0);
    run_until_done(50);
    exp4 = '{32'hC300_3FFE, 32'hC300_3FFF, 32'hC300_0000, 32'hC300_0001};
    check("w_beats", bd.size(), 4);
    for (int i = 0; i < 4; i++) check("w_data", bd[i], exp4[i]);
    check("w_last", bl[3], 1);

    // Reader chasing the writer
    wr_count = 16'h0080;
    tick(); tick();
    clear_mon();
    begin
      int wchg[3];
      pulse_start(14'h0020, 15'd3, t0);
      for (int i = 0; i < 3; i++) begin
        repeat (10) tick();
        wr_count = wr_count + 16'd4;
        wchg[i] = cyc;
      end
      run_until_done(40);
      check("c_beats", bd.size(), 3);
      for (int i = 0; i < 3; i++) begin
        check("c_data", bd[i], 32'hC300_0020 + i);
        check("c_cycle", bc[i], wchg[i] + 3);
      end
      check("c_ovr", ovr_seen, 0);
    end

    // Backpressure: alternating ready plus a 5-cycle hold
    wr_count = 16'h2000;
    tick(); tick();
    clear_mon();
    pulse_start(14'h0100, 15'd8, t0);
    for (int k = 0; k < 200 && dq.size() == 0; k++) begin
      m_tready = (k >= 6 && k < 11) ? 1'b0 : (k % 2 == 0);
      tick();
    end
    m_tready = 1'b1;
    tick();
    check("bp_done", dq.size(), 1);
    check("bp_beats", bd.size(), 8);
    for (int i = 0; i < 8; i++) begin
      check("bp_data", bd[i], 32'hC300_0100 + i);
      check("bp_last", bl[i], (i == 7));
    end

    // Zero length
    clear_mon();
    pulse_start(14'h0055, 15'd0, t0);
    repeat (4) tick();
    check("z_busy", busy_cnt, 1);
    check("z_done", dq.size(), 1);
    check("z_done_cyc", dq[0], t0 + 1);
    check("z_beats", bd.size(), 0);

    // Oversized length clamps to the full buffer; writer parked mid-way, then moved
    wr_count = 16'h8000;
    tick(); tick();
    clear_mon();
    pulse_start(14'h0000, 15'h7FFF, t0);
    repeat (9000) tick();
    wr_count = 16'h0000;
    run_until_done(12000);
    check("f_beats", bd.size(), 16384);
    err_d = 0;
    err_l = 0;
    for (int i = 0; i < bd.size(); i++) begin
      if (bd[i] !== (32'hC300_0000 | i)) err_d++;
      if (bl[i] !== (i == 16383)) err_l++;
    end
    check("f_data_err", err_d, 0);
    check("f_last_err", err_l, 0);
    check("f_ovr", ovr_seen, 0);

    // Overrun: writer jumps onto the stalled read address
    wr_count = 16'h0C00;
    tick(); tick();
    clear_mon();
    m_tready = 1'b0;
    pulse_start(14'h0200, 15'd4, t0);
    repeat (6) tick();
    check("o_pre", overrun, 0);
    wr_count = 16'h0808;
    repeat (3) tick();
    check("o_set", overrun, 1);
    wr_count = 16'h0C00;
    tick();
    m_tready = 1'b1;
    run_until_done(50);
    check("o_beats", bd.size(), 4);
    for (int i = 0; i < 4; i++) check("o_data", bd[i], 32'hC300_0200 + i);
    check("o_sticky", overrun, 1);

    // Reset mid-readout, then a normal readout
    wr_count = 16'h2000;
    tick(); tick();
    clear_mon();
    pulse_start(14'h0400, 15'd8, t0);
    check("r_ovr_clr", overrun, 0);
    repeat (3) tick();
    check("r_active", m_tvalid, 1);
    rst = 1'b1;
    tick();
    check_idle_zero("mid_rst");
    rst = 1'b0;
    tick();
    clear_mon();
    pulse_start(14'h0500, 15'd2, t0);
    run_until_done(50);
    check("r_beats", bd.size(), 2);
    check("r_data0", bd[0], 32'hC300_0500);
    check("r_data1", bd[1], 32'hC300_0501);
    check("r_first_cyc", bc[0], t0 + 3);
    check("r_last", bl[1], 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/iq_bram_reader.md
IQ_BRAM_READER -- requirements
Module: iq_bram_reader

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 14, meaning the IQ BRAM word address width (2^ADDR_W words).
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the IQ BRAM word width (packed I/Q).
REQ-003 Port clk  input  1  system clock (normally adc_clk); all logic on rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port wr_count  input  16  writer's CIC pulse counter; writer's current address is wr_ptr = wr_count[15:2].
REQ-006 Port start  input  1  single-cycle request to begin a readout; sampled only in IDLE.
REQ-007 Port start_addr  input  ADDR_W  first BRAM address to read.
REQ-008 Port length  input  ADDR_W+1  number of words to read; values above 2^ADDR_W are clamped to 2^ADDR_W.
REQ-009 Port bram_en  output  1  BRAM read enable.
REQ-010 Port bram_addr  output  ADDR_W  BRAM read address.
REQ-011 Port bram_dout  input  DATA_W  BRAM read data, valid exactly 1 cycle after bram_en.
REQ-012 Port m_tdata / m_tvalid / m_tlast  output  DATA_W / 1 / 1  output stream data, valid, last-beat flag.
REQ-013 Port m_tready  input  1  output stream ready from consumer.
REQ-014 Port busy  output  1  high from accepted start until done.
REQ-015 Port done  output  1  one-cycle pulse when the final beat is accepted or a zero-length request completes.
REQ-016 Port overrun  output  1  sticky flag: writer lapped the reader during the current readout.

Function
REQ-017 States SHALL be IDLE, READ, DRAIN, FINISH; IDLE->READ on start with clamped length>0; IDLE->FINISH on start with length==0; READ->DRAIN after the last read is issued; DRAIN->FINISH when the last beat handshakes; FINISH->IDLE unconditionally after 1 cycle (done=1 in FINISH).
REQ-018 On accepted start, rd_addr SHALL load start_addr, remaining-issue and remaining-beat counters SHALL load clamped length, and overrun SHALL clear.
REQ-019 start while not in IDLE SHALL be ignored with no effect on any state.
REQ-020 A read SHALL be issued (bram_en=1, bram_addr=rd_addr) in READ only when rd_addr != wr_ptr and (buffered words + in-flight reads) < 2.
REQ-021 After each issued read rd_addr SHALL increment modulo 2^ADDR_W (2^ADDR_W-1 wraps to 0).
REQ-022 Returned bram_dout SHALL be captured into a 2-entry output buffer; no word may be dropped or duplicated under any m_tready pattern.
REQ-023 A beat transfers when m_tvalid && m_tready; m_tdata/m_tlast SHALL hold stable while m_tvalid=1 and m_tready=0.
REQ-024 m_tlast SHALL be 1 only on the beat whose remaining-beat count equals 1.
REQ-025 Minimum latency start->first m_tvalid SHALL be 3 cycles (state load, issue, capture) when data is available and m_tready=1.
REQ-026 With m_tready held 1 and data available, throughput SHALL be one beat per cycle.
REQ-027 overrun SHALL set when, in READ or DRAIN, wr_ptr changes and its new value equals rd_addr while issue count remains >0; it SHALL hold until next accepted start or rst, and readout SHALL continue.
REQ-028 If wr_ptr and rd_addr advance in the same cycle, the read-gating comparison SHALL use the registered values of that cycle (no combinational path from wr_count to bram_en beyond one compare).
REQ-029 wr_count SHALL be registered once before use.

Reset
REQ-030 On rst (including mid-readout), state SHALL go to IDLE, buffer and in-flight tracking clear, and busy, done, overrun, m_tvalid, m_tlast, bram_en SHALL be 0, bram_addr and counters 0, on the next edge.
REQ-031 A BRAM response in flight during rst SHALL be discarded.

Verification
REQ-032 wr_count=0x0100 (wr_ptr=0x40), start_addr=0x10, length=4, m_tready=1 -> beats from addresses 0x10..0x13 on consecutive cycles, m_tlast on 4th, done 1 cycle later.
REQ-033 start_addr=0x3FFE, length=4, wr_ptr=0x0010 -> addresses 0x3FFE,0x3FFF,0x0000,0x0001 in order.
REQ-034 start_addr=wr_ptr=0x20, length=3, wr_count +4 every 10 cycles -> each word emitted only after wr_ptr passes it; no overrun.
REQ-035 length=8, m_tready toggling 1/0 each cycle plus a 5-cycle low hold -> 8 beats, correct order, data stable during stalls, no loss.
REQ-036 length=0 -> no beats, busy 1 cycle, done pulse; length=0x7FFF -> 16384 beats; rst asserted mid-readout -> all outputs 0 next cycle, next start behaves normally.
